// File: rtl/mprj_test_sequencer_pkg.sv
// Shared types and constants for the mprj test sequencer: FSM state encoding,
// default signature codes and a counter-width helper.
package mprj_test_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PWR_UP   = 3'd1,
        ST_RST_HOLD = 3'd2,
        ST_RUN      = 3'd3,
        ST_PASS     = 3'd4,
        ST_FAIL     = 3'd5
    } seq_state_e;

    localparam logic [15:0] DEF_PASS_CODE = 16'hAB60;
    localparam logic [15:0] DEF_FAIL_CODE = 16'hAB61;

    // Bits needed for a counter that takes n_states distinct values (min 1).
    function automatic int cnt_w(input int n_states);
        return (n_states <= 2) ? 1 : $clog2(n_states);
    endfunction

endpackage

// File: rtl/mprj_test_sequencer_if.sv
// Control/status bundle between a bench or board and mprj_test_sequencer.
// Carries hb_err only when MPRJ_TEST_HEARTBEAT_EN is defined.
interface mprj_test_sequencer_if #(
    parameter int NUM_PWR = 2,
    parameter int IO_W    = 38,
    parameter int EB_W    = 7
);
    logic                start;
    logic                abort;
    logic [IO_W-1:0]     mprj_io_in;
    logic [NUM_PWR-1:0]  pwr_en;
    logic                core_resetb;
    logic [2:0]          state;
    logic [EB_W-1:0]     elapsed_blks;
    logic                done;
    logic                pass;
    logic                fail;
    logic                timeout;
`ifdef MPRJ_TEST_HEARTBEAT_EN
    logic                hb_err;

    modport slave  (input start, abort, mprj_io_in,
                    output pwr_en, core_resetb, state, elapsed_blks,
                           done, pass, fail, timeout, hb_err);
    modport master (output start, abort, mprj_io_in,
                    input pwr_en, core_resetb, state, elapsed_blks,
                          done, pass, fail, timeout, hb_err);
`else
    modport slave  (input start, abort, mprj_io_in,
                    output pwr_en, core_resetb, state, elapsed_blks,
                           done, pass, fail, timeout);
    modport master (output start, abort, mprj_io_in,
                    input pwr_en, core_resetb, state, elapsed_blks,
                          done, pass, fail, timeout);
`endif
endinterface

// File: rtl/mprj_test_sequencer_blk_timer.sv
// Block-based watchdog: a BLK_CYC cycle counter feeding a completed-block count.
// expired flags the cycle whose wrap completes block TIMEOUT_BLKS.
module mprj_blk_timer
    import mprj_test_pkg::*;
#(
    parameter int BLK_CYC      = 1000,
    parameter int TIMEOUT_BLKS = 75,
    parameter int BW           = 7
) (
    input  logic          clock,
    input  logic          resetb,
    input  logic          en,
    input  logic          clr,
    output logic [BW-1:0] blk_cnt,
    output logic          expired
);
    localparam int CW = cnt_w(BLK_CYC);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          wrap;

    assign wrap = (cyc_q == CW'(BLK_CYC - 1));

    always_comb begin
        cyc_d = cyc_q;
        blk_d = blk_q;
        if (clr) begin
            cyc_d = '0;
            blk_d = '0;
        end else if (en) begin
            if (wrap) begin
                cyc_d = '0;
                blk_d = blk_q + 1'b1;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cyc_q <= '0;
            blk_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            blk_q <= blk_d;
        end
    end

    assign blk_cnt = blk_q;
    assign expired = en && !clr && wrap && (blk_q == BW'(TIMEOUT_BLKS - 1));

endmodule

// File: rtl/mprj_test_sequencer.sv
// Power-up / reset / watchdog sequencer with signature-based PASS/FAIL result.
// Optional heartbeat watchdog enabled with `define MPRJ_TEST_HEARTBEAT_EN.
module mprj_test_sequencer
    import mprj_test_pkg::*;
#(
    parameter int               NUM_PWR      = 2,
    parameter int               PWR_STEP     = 8,
    parameter int               RST_DLY      = 40,
    parameter int               IO_W         = 38,
    parameter int               SIG_LSB      = 16,
    parameter int               SIG_W        = 16,
    parameter logic [SIG_W-1:0] PASS_CODE    = SIG_W'(DEF_PASS_CODE),
    parameter logic [SIG_W-1:0] FAIL_CODE    = SIG_W'(DEF_FAIL_CODE),
    parameter int               STABLE_CYC   = 4,
    parameter int               BLK_CYC      = 1000,
    parameter int               TIMEOUT_BLKS = 75
`ifdef MPRJ_TEST_HEARTBEAT_EN
    ,
    parameter int               HB_BIT       = 15,
    parameter int               HB_CYC       = 2000
`endif
) (
    input  logic                  clock,
    input  logic                  resetb,
    mprj_test_sequencer_if.slave  bus
);
    localparam int SEQ_MAX = (NUM_PWR * PWR_STEP > RST_DLY) ? NUM_PWR * PWR_STEP : RST_DLY;
    localparam int SEQ_W   = cnt_w(SEQ_MAX + 1);
    localparam int STB_W   = cnt_w(STABLE_CYC + 1);
    localparam int EB_W    = cnt_w(TIMEOUT_BLKS + 1);

    seq_state_e         state_q, state_d;
    logic [SEQ_W-1:0]   step_q, step_d, step_inc;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [NUM_PWR-1:0] pwr_en_q, pwr_en_d, pwr_hit;
    logic               core_resetb_q, core_resetb_d;
    logic               done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic               tmr_en, tmr_clr, tmr_expired;
    logic [EB_W-1:0]    elapsed_blks;

`ifdef MPRJ_TEST_HEARTBEAT_EN
    localparam int HB_W = cnt_w(HB_CYC);
    logic            hb_bit_q, hb_bit_d, hb_prev_q, hb_prev_d, hb_err_q, hb_err_d;
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            hb_toggle;
    assign hb_toggle = (hb_bit_q != hb_prev_q);
`endif

    assign step_inc = step_q + 1'b1;

    // Enable i fires on entry-relative cycle (i+1)*PWR_STEP, entry cycle = 1.
    generate
        for (genvar gi = 0; gi < NUM_PWR; gi++) begin : g_pwr_hit
            assign pwr_hit[gi] = (step_inc == SEQ_W'((gi + 1) * PWR_STEP));
        end
    endgenerate

    assign tmr_en = (state_q == ST_RUN);

    mprj_blk_timer #(
        .BLK_CYC      (BLK_CYC),
        .TIMEOUT_BLKS (TIMEOUT_BLKS),
        .BW           (EB_W)
    ) u_blk_timer (
        .clock   (clock),
        .resetb  (resetb),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .blk_cnt (elapsed_blks),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        stable_d      = stable_q;
        sig_d         = bus.mprj_io_in[SIG_LSB +: SIG_W];
        pwr_en_d      = pwr_en_q;
        core_resetb_d = core_resetb_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        tmr_clr       = 1'b0;
`ifdef MPRJ_TEST_HEARTBEAT_EN
        hb_bit_d      = bus.mprj_io_in[HB_BIT];
        hb_prev_d     = hb_bit_q;
        hb_cnt_d      = hb_cnt_q;
        hb_err_d      = hb_err_q;
`endif
        if (bus.abort) begin
            state_d       = ST_OFF;
            step_d        = '0;
            stable_d      = '0;
            pwr_en_d      = '0;
            core_resetb_d = 1'b0;
            done_d        = 1'b0;
            pass_d        = 1'b0;
            fail_d        = 1'b0;
            timeout_d     = 1'b0;
            tmr_clr       = 1'b1;
`ifdef MPRJ_TEST_HEARTBEAT_EN
            hb_cnt_d      = '0;
            hb_err_d      = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_OFF, ST_PASS, ST_FAIL: begin
                    // Restart is a clean re-power: drop rails and results now.
                    if (bus.start) begin
                        state_d       = ST_PWR_UP;
                        step_d        = '0;
                        stable_d      = '0;
                        pwr_en_d      = '0;
                        core_resetb_d = 1'b0;
                        done_d        = 1'b0;
                        pass_d        = 1'b0;
                        fail_d        = 1'b0;
                        timeout_d     = 1'b0;
                        tmr_clr       = 1'b1;
`ifdef MPRJ_TEST_HEARTBEAT_EN
                        hb_cnt_d      = '0;
                        hb_err_d      = 1'b0;
`endif
                    end
                end
                ST_PWR_UP: begin
                    step_d   = step_inc;
                    pwr_en_d = pwr_en_q | pwr_hit;
                    if (pwr_hit[NUM_PWR-1]) begin
                        state_d = ST_RST_HOLD;
                        step_d  = '0;
                    end
                end
                ST_RST_HOLD: begin
                    step_d = step_inc;
                    if (step_q == SEQ_W'(RST_DLY - 1)) begin
                        state_d       = ST_RUN;
                        step_d        = '0;
                        stable_d      = '0;
                        core_resetb_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    stable_d = (sig_q == PASS_CODE) ? stable_q + 1'b1 : '0;
`ifdef MPRJ_TEST_HEARTBEAT_EN
                    hb_cnt_d = hb_toggle ? '0 : hb_cnt_q + 1'b1;
`endif
                    if (sig_q == FAIL_CODE) begin
                        state_d = ST_FAIL;
                        done_d  = 1'b1;
                        fail_d  = 1'b1;
`ifdef MPRJ_TEST_HEARTBEAT_EN
                    end else if (!hb_toggle && hb_cnt_q == HB_W'(HB_CYC - 1)) begin
                        state_d  = ST_FAIL;
                        done_d   = 1'b1;
                        fail_d   = 1'b1;
                        hb_err_d = 1'b1;
`endif
                    end else if (sig_q == PASS_CODE && stable_q == STB_W'(STABLE_CYC - 1)) begin
                        state_d = ST_PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else if (tmr_expired) begin
                        state_d   = ST_FAIL;
                        done_d    = 1'b1;
                        fail_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q       <= ST_OFF;
            step_q        <= '0;
            stable_q      <= '0;
            sig_q         <= '0;
            pwr_en_q      <= '0;
            core_resetb_q <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            stable_q      <= stable_d;
            sig_q         <= sig_d;
            pwr_en_q      <= pwr_en_d;
            core_resetb_q <= core_resetb_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
        end
    end

`ifdef MPRJ_TEST_HEARTBEAT_EN
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            hb_bit_q  <= 1'b0;
            hb_prev_q <= 1'b0;
            hb_cnt_q  <= '0;
            hb_err_q  <= 1'b0;
        end else begin
            hb_bit_q  <= hb_bit_d;
            hb_prev_q <= hb_prev_d;
            hb_cnt_q  <= hb_cnt_d;
            hb_err_q  <= hb_err_d;
        end
    end
    assign bus.hb_err = hb_err_q;
`endif

    assign bus.state        = state_q;
    assign bus.pwr_en       = pwr_en_q;
    assign bus.core_resetb  = core_resetb_q;
    assign bus.elapsed_blks = elapsed_blks;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.fail         = fail_q;
    assign bus.timeout      = timeout_q;

endmodule
